// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 holds the accepted operands/opcode; the result and flags are computed
// combinationally from S1 and captured into S2 when S1 advances. A persistent
// carry register supports multi-word ADC/SBC chains.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alu_func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             func_err
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [3:0]       s1_func_q, s1_func_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;
  logic             c_reg_q, c_reg_d;

  logic             s2_adv, in_acc;
  logic [WIDTH-1:0] res, bp;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic             cin, is_arith, fc, fv, ferr;

  // Handshake: S1 may take a new op when empty or when it moves into S2 this cycle
  assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !rst && (!s1_valid_q || s2_adv);
  assign in_acc   = in_valid && in_ready;

  assign out_valid = s2_valid_q;
  assign alu_out   = out_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign func_err  = err_q;

  // Result and flags from the operation sitting in S1
  always_comb begin
    res      = '0;
    bp       = s1_b_q;
    cin      = 1'b0;
    is_arith = 1'b0;
    ferr     = 1'b0;
    fc       = 1'b0;
    fv       = 1'b0;
    sh       = s1_b_q[SHW-1:0];
    case (s1_func_q)
      4'd0:  res = s1_b_q;
      4'd1:  is_arith = 1'b1;
      4'd2:  begin is_arith = 1'b1; bp = ~s1_b_q; cin = 1'b1;    end
      4'd3:  res = s1_a_q & s1_b_q;
      4'd4:  res = s1_a_q | s1_b_q;
      4'd5:  res = s1_a_q << sh;
      4'd6:  res = s1_a_q >> sh;
      4'd7:  res = s1_a_q ^ s1_b_q;
      4'd8:  res = $unsigned($signed(s1_a_q) >>> sh);
      4'd9:  begin is_arith = 1'b1; cin = c_reg_q;                end
      4'd10: begin is_arith = 1'b1; bp = ~s1_b_q; cin = c_reg_q; end
      4'd11: res = ~s1_a_q;
      default: ferr = 1'b1;
    endcase
    sum = {1'b0, s1_a_q} + {1'b0, bp} + {{WIDTH{1'b0}}, cin};
    if (is_arith) begin
      res = sum[WIDTH-1:0];
      fc  = sum[WIDTH];
      fv  = (s1_a_q[WIDTH-1] == bp[WIDTH-1]) && (res[WIDTH-1] != s1_a_q[WIDTH-1]);
    end
  end

  // Next-state for both pipeline stages and the chain carry
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_func_d  = s1_func_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    z_d        = z_q;
    n_d        = n_q;
    c_d        = c_q;
    v_d        = v_q;
    err_d      = err_q;
    c_reg_d    = c_reg_q;

    if (in_acc) begin
      s1_valid_d = 1'b1;
      s1_a_d     = alu_a;
      s1_b_d     = alu_b;
      s1_func_d  = alu_func;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = 1'b1;
      out_d      = res;
      z_d        = (res == '0);
      n_d        = res[WIDTH-1];
      c_d        = fc;
      v_d        = fv;
      err_d      = ferr;
      if (is_arith) c_reg_d = fc;
    end else if (s2_valid_q && out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_func_q  <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      err_q      <= 1'b0;
      c_reg_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_func_q  <= s1_func_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      z_q        <= z_d;
      n_q        <= n_d;
      c_q        <= c_d;
      v_q        <= v_d;
      err_q      <= err_d;
      c_reg_q    <= c_reg_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=16): directed cases plus randomized traffic
// checked against an arithmetic reference model driven from accepted inputs.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_func;
  logic        flag_z, flag_n, flag_c, flag_v, func_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_viol = 0;

  // packed result: {err, v, c, n, z, out[15:0]}
  logic [20:0] exp_q[$];
  logic [20:0] got_q[$];
  int          stamp_q[$];
  bit          mc = 1'b0;
  bit          prev_stall = 1'b0;
  logic [20:0] prev_val = '0;
  logic [20:0] cur;

  assign cur = {func_err, flag_v, flag_c, flag_n, flag_z, alu_out};

  alu_pipe #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .func_err(func_err)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] pk(input logic [15:0] r, input bit z, input bit n,
                                     input bit c, input bit v, input bit e);
    return {e, v, c, n, z, r};
  endfunction

  // Reference: plain integer arithmetic over the opcode table
  function automatic logic [20:0] ref_op(input logic [3:0] f, input logic [15:0] a16,
                                         input logic [15:0] b16, input bit creg);
    int a, b, r, sh, sa, sbp, bp, cin, sum, t;
    bit arith, cf, vf, er;
    a = int'(a16); b = int'(b16); sh = b & 15;
    sa = (a >= 32768) ? a - 65536 : a;
    r = 0; arith = 0; cf = 0; vf = 0; er = 0; bp = b; cin = 0;
    case (f)
      4'd0:  r = b;
      4'd1:  begin arith = 1; bp = b; cin = 0; end
      4'd2:  begin arith = 1; bp = (~b) & 'hFFFF; cin = 1; end
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = (a << sh) & 'hFFFF;
      4'd6:  r = a >> sh;
      4'd7:  r = a ^ b;
      4'd8:  r = (sa >>> sh) & 'hFFFF;
      4'd9:  begin arith = 1; bp = b; cin = int'(creg); end
      4'd10: begin arith = 1; bp = (~b) & 'hFFFF; cin = int'(creg); end
      4'd11: r = (~a) & 'hFFFF;
      default: begin r = 0; er = 1; end
    endcase
    if (arith) begin
      sum = a + bp + cin;
      r   = sum & 'hFFFF;
      cf  = (sum >> 16) != 0;
      sbp = (bp >= 32768) ? bp - 65536 : bp;
      t   = sa + sbp + cin;
      vf  = (t > 32767) || (t < -32768);
    end
    return pk(r[15:0], r == 0, r[15], cf, vf, er);
  endfunction

  // Observer: logs accepted ops through the model and drained results
  always @(negedge clk) begin
    logic [20:0] e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      mc = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid && cur !== prev_val) stall_viol++;
      prev_stall = out_valid && !out_ready;
      prev_val   = cur;
      if (out_valid && out_ready) begin
        got_q.push_back(cur);
        stamp_q.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        e = ref_op(alu_func, alu_a, alu_b, mc);
        exp_q.push_back(e);
        if (alu_func inside {4'd1, 4'd2, 4'd9, 4'd10}) mc = e[18];
      end
    end
  end

  task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    bit done = 0;
    in_valid = 1'b1; alu_func = f; alu_a = a; alu_b = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        errors++;
        $display("FAIL issue_timeout func=%0d in_ready stuck at %b", f, in_ready);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (got_q.size() != exp_q.size() && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL drain_timeout got=%0d expected=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic clear_logs();
    got_q.delete(); exp_q.delete(); stamp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_a = '0; alu_b = '0; alu_func = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (cur !== 21'h0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", cur); end
  endtask

  task automatic test_latency();
    clear_logs();
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; alu_func = 4'd1; alu_a = 16'hFFFF; alu_b = 16'h0001;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle1_valid got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_cycle2_valid got=%b exp=1", out_valid); end
    checks++;
    if (cur !== pk(16'h0000, 1, 0, 1, 0, 0)) begin
      errors++; $display("FAIL lat_add_result got=%h exp=%h", cur, pk(16'h0000, 1, 0, 1, 0, 0));
    end
    drain();
    clear_logs();
  endtask

  task automatic test_directed();
    logic [3:0]  tf [15];
    logic [15:0] ta [15];
    logic [15:0] tb [15];
    logic [20:0] te [15];
    tf = '{4'd1, 4'd2, 4'd2, 4'd1, 4'd9, 4'd1, 4'd3, 4'd9, 4'd5, 4'd6, 4'd8, 4'd8, 4'd7, 4'd11, 4'd13};
    ta = '{16'hFFFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0F0F, 16'h0000,
           16'h0001, 16'h8000, 16'h8000, 16'h4000, 16'hAAAA, 16'h00FF, 16'h1234};
    tb = '{16'h0001, 16'h0001, 16'h0002, 16'h0001, 16'h0000, 16'h0001, 16'h00FF, 16'h0000,
           16'h000F, 16'h0004, 16'h0004, 16'h0000, 16'hFFFF, 16'h0000, 16'h5678};
    te = '{pk(16'h0000, 1, 0, 1, 0, 0), pk(16'h7FFF, 0, 0, 1, 1, 0), pk(16'hFFFF, 0, 1, 0, 0, 0),
           pk(16'h0000, 1, 0, 1, 0, 0), pk(16'h0001, 0, 0, 0, 0, 0), pk(16'h0000, 1, 0, 1, 0, 0),
           pk(16'h000F, 0, 0, 0, 0, 0), pk(16'h0001, 0, 0, 0, 0, 0), pk(16'h8000, 0, 1, 0, 0, 0),
           pk(16'h0800, 0, 0, 0, 0, 0), pk(16'hF800, 0, 1, 0, 0, 0), pk(16'h4000, 0, 0, 0, 0, 0),
           pk(16'h5555, 0, 0, 0, 0, 0), pk(16'hFF00, 0, 1, 0, 0, 0), pk(16'h0000, 1, 0, 0, 0, 1)};
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) issue(tf[i], ta[i], tb[i]);
    drain();
    checks++;
    if (got_q.size() != 15) begin
      errors++; $display("FAIL directed_count got=%0d exp=15", got_q.size());
    end else begin
      for (int i = 0; i < 15; i++) begin
        checks++;
        if (got_q[i] !== te[i]) begin
          errors++; $display("FAIL directed_%0d func=%0d got=%h exp=%h", i, tf[i], got_q[i], te[i]);
        end
      end
    end
    clear_logs();
  endtask

  task automatic test_backpressure();
    clear_logs();
    out_ready = 1'b0;
    issue(4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom));
    issue(4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom));
    in_valid = 1'b1; alu_func = 4'($urandom_range(0, 11)); alu_a = 16'($urandom); alu_b = 16'($urandom);
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() != 2 || cur !== exp_q[0]) begin
        errors++; $display("FAIL bp_hold valid=%b got=%h exp=%h", out_valid, cur, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    checks++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      errors++; $display("FAIL bp_count got=%0d exp=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL bp_order_%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (stamp_q[1] != stamp_q[0] + 1 || stamp_q[2] != stamp_q[1] + 1) begin
        errors++; $display("FAIL bp_consecutive stamps=%0d,%0d,%0d exp consecutive",
                           stamp_q[0], stamp_q[1], stamp_q[2]);
      end
    end
    clear_logs();
  endtask

  task automatic test_random();
    bit rdone = 0;
    clear_logs();
    stall_viol = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [3:0]  f;
          logic [15:0] a, b;
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          f = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(9, 10)) : 4'($urandom_range(0, 15));
          a = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
          b = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
          issue(f, a, b);
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    checks++;
    if (got_q.size() != 300 || exp_q.size() != 300) begin
      errors++; $display("FAIL rand_count got=%0d exp=300", got_q.size());
    end else begin
      for (int i = 0; i < 300; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++; $display("FAIL rand_stall_stable violations=%0d exp=0", stall_viol);
    end
    clear_logs();
  endtask

  task automatic test_reset_midstream();
    clear_logs();
    out_ready = 1'b0;
    issue(4'd1, 16'hFFFF, 16'h0001);
    issue(4'd2, 16'h0005, 16'h0003);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got=%b exp=1", out_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    got_q.delete();
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_valid got=%b exp=0", out_valid); end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL mid_stale_count got=%0d exp=0", got_q.size()); end
    @(posedge clk); #1;
    issue(4'd9, 16'h0001, 16'h0001);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== pk(16'h0002, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL mid_adc got=%h exp=%h", (got_q.size() != 0) ? got_q[0] : 21'h0,
                         pk(16'h0002, 0, 0, 0, 0, 0));
    end
    clear_logs();
  endtask

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
